multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Multiply/divide sequencer: accepts one operation from the pipeline, pulses the
// arithmetic unit, waits for its result and hands it to register writeback.
// Optional watchdog on the WAIT state is enabled by defining MULTDIV_SEQ_TIMEOUT_EN.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_a,
  input  logic [15:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_exc_q, wb_exc_d;
  logic        timeout;

`ifdef MULTDIV_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires in the TIMEOUT-th WAIT cycle; a simultaneous md_resultRDY still wins.
  assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

  // Watchdog next value: zeroed while issuing so the first WAIT cycle sees 0
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        // rd = 0 has no architectural destination, so writeback is skipped
        if (md_resultRDY || timeout) begin
          state_d = (rd_q != 5'd0) ? StWb : StIdle;
        end
      end
      StWb:    if (wb_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Captured operands and result next values
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_exc_d  = wb_exc_q;
    if ((state_q == StIdle) && issue_valid) begin
      op_d = issue_op;
      a_d  = issue_a;
      b_d  = issue_b;
      rd_d = issue_rd;
    end
    if (state_q == StWait) begin
      if (md_resultRDY) begin
        wb_data_d = md_result;
        wb_exc_d  = md_exception;
      end else if (timeout) begin
        wb_data_d = 32'd0;
        wb_exc_d  = 1'b1;
      end
    end
  end

  // Captured operands and result registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_q      <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 16'd0;
      rd_q      <= 5'd0;
      wb_data_q <= 32'd0;
      wb_exc_q  <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  // Outputs decoded from state; everything not owned by a state is held at 0
  always_comb begin
    issue_ready  = 1'b0;
    md_operandA  = 32'd0;
    md_operandB  = 16'd0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    wb_exception = 1'b0;
    unique case (state_q)
      StIdle: issue_ready = 1'b1;
      StIssue: begin
        md_operandA  = a_q;
        md_operandB  = b_q;
        md_ctrl_MULT = ~op_q;
        md_ctrl_DIV  = op_q;
      end
      StWait: begin
        md_operandA = a_q;
        md_operandB = b_q;
      end
      StWb: begin
        wb_valid     = 1'b1;
        wb_rd        = rd_q;
        wb_data      = wb_data_q;
        wb_exception = wb_exc_q;
      end
      default: ;
    endcase
    busy = ~issue_ready;
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer. The bench plays the arithmetic unit,
// predicts every start pulse and writeback at issue time, and a monitor thread
// pops and compares them when the DUT presents them.
module tb_multdiv_sequencer;

`ifdef MULTDIV_SEQ_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif
  localparam int To = 8;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_op;
  logic [31:0] issue_a;
  logic [15:0] issue_b;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        busy;
  logic [31:0] md_operandA;
  logic [15:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_ack;

  multdiv_sequencer #(
    .TIMEOUT(To)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy        (busy),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV (md_ctrl_DIV),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exception(wb_exception),
    .wb_ack      (wb_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;

  // {op, a, b} expected at each start pulse
  logic [48:0] start_q[$];
  // {rd, data, exception} expected at each writeback
  logic [37:0] wb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_issue_ready"}, 64'(issue_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_operand_a"}, 64'(md_operandA), 64'd0);
    chk({tag, "_operand_b"}, 64'(md_operandB), 64'd0);
    chk({tag, "_ctrl_mult"}, 64'(md_ctrl_MULT), 64'd0);
    chk({tag, "_ctrl_div"}, 64'(md_ctrl_DIV), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    chk({tag, "_wb_exception"}, 64'(wb_exception), 64'd0);
  endtask

  // Pops the scoreboards whenever the DUT presents a start pulse or writeback
  task automatic monitor();
    logic [48:0] se;
    logic [37:0] we;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    logic        h_exc;
    bit          wb_act;
    wb_act = 1'b0;
    h_rd   = '0;
    h_data = '0;
    h_exc  = 1'b0;
    forever begin
      @(negedge clock);
      chk("busy_is_not_ready", 64'(busy), 64'(!issue_ready));
      chk("start_exclusive", 64'(md_ctrl_MULT & md_ctrl_DIV), 64'd0);
      if (md_ctrl_MULT || md_ctrl_DIV) begin
        if (start_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got pulse div=%0d, want no pulse", md_ctrl_DIV);
        end else begin
          se = start_q.pop_front();
          chk("start_is_div", 64'(md_ctrl_DIV), 64'(se[48]));
          chk("start_operand_a", 64'(md_operandA), 64'(se[47:16]));
          chk("start_operand_b", 64'(md_operandB), 64'(se[15:0]));
        end
      end
      if (issue_ready) begin
        chk("idle_operand_a", 64'(md_operandA), 64'd0);
        chk("idle_operand_b", 64'(md_operandB), 64'd0);
        chk("idle_wb_valid", 64'(wb_valid), 64'd0);
        chk("idle_start", 64'(md_ctrl_MULT | md_ctrl_DIV), 64'd0);
      end
      if (wb_valid) begin
        if (!wb_act) begin
          wb_act = 1'b1;
          h_rd   = wb_rd;
          h_data = wb_data;
          h_exc  = wb_exception;
          if (wb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wb: got rd=%0d data=0x%0h, want no writeback",
                     wb_rd, wb_data);
          end else begin
            we = wb_q.pop_front();
            chk("wb_rd", 64'(wb_rd), 64'(we[37:33]));
            chk("wb_data", 64'(wb_data), 64'(we[32:1]));
            chk("wb_exception", 64'(wb_exception), 64'(we[0]));
          end
        end else begin
          chk("wb_rd_stable", 64'(wb_rd), 64'(h_rd));
          chk("wb_data_stable", 64'(wb_data), 64'(h_data));
          chk("wb_exception_stable", 64'(wb_exception), 64'(h_exc));
        end
      end else begin
        wb_act = 1'b0;
      end
    end
  endtask

  // Issues one operation and plays the arithmetic unit for it.
  // delay: WAIT cycles before the unit answers; spur: junk md_resultRDY/wb_ack in ISSUE;
  // hold: keep a second issue request pending throughout WB.
  task automatic run_op(input bit op, input logic [31:0] a, input logic [15:0] b,
                        input logic [4:0] rd, input int delay, input int ack_dly,
                        input bit spur, input bit hold);
    logic [31:0] res;
    logic        exc;
    bit          timed_out;
    int          n;
    if (!op) begin
      res = a * {16'd0, b};
      exc = 1'b0;
    end else if (b == 16'd0) begin
      res = 32'hFFFF_FFFF;
      exc = 1'b1;
    end else begin
      res = a / {16'd0, b};
      exc = 1'b0;
    end
    timed_out = ToEn && (delay >= To);

    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_rd    = rd;
    issue_valid = 1'b1;
    n = 0;
    while (!issue_ready && n < 100) begin
      tick();
      n++;
    end
    if (!issue_ready) begin
      chk("issue_ready_timeout", 64'(issue_ready), 64'd1);
      issue_valid = 1'b0;
      return;
    end
    start_q.push_back({op, a, b});
    if (rd != 5'd0) begin
      if (timed_out) wb_q.push_back({rd, 32'd0, 1'b1});
      else wb_q.push_back({rd, res, exc});
    end
    tick();
    issue_valid = 1'b0;
    issue_a     = $urandom;

    // ISSUE cycle: unit inputs here must be ignored
    chk("start_pulse_present", 64'(md_ctrl_MULT | md_ctrl_DIV), 64'd1);
    if (spur) begin
      md_resultRDY = 1'b1;
      md_result    = $urandom;
      md_exception = 1'b1;
      wb_ack       = 1'b1;
    end
    tick();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    wb_ack       = 1'b0;

    if (timed_out) begin
      n = 0;
      while (!wb_valid && !issue_ready && n < 200) begin
        tick();
        n++;
      end
      chk("timeout_wait_cycles", 64'(n), 64'(To));
    end else begin
      repeat (delay) tick();
      chk("wait_operand_a", 64'(md_operandA), 64'(a));
      chk("wait_operand_b", 64'(md_operandB), 64'(b));
      md_resultRDY = 1'b1;
      md_result    = res;
      md_exception = exc;
      tick();
      md_resultRDY = 1'b0;
      md_result    = $urandom;
      md_exception = 1'b0;
    end

    if (rd == 5'd0) begin
      chk("rd0_ready_after_result", 64'(issue_ready), 64'd1);
      chk("rd0_no_wb", 64'(wb_valid), 64'd0);
      return;
    end
    chk("wb_valid_after_result", 64'(wb_valid), 64'd1);
    if (hold) begin
      issue_valid = 1'b1;
      issue_op    = ~op;
      issue_a     = $urandom;
      issue_b     = 16'($urandom);
      issue_rd    = 5'($urandom_range(1, 31));
    end
    repeat (ack_dly) tick();
    wb_ack = 1'b1;
    tick();
    wb_ack      = 1'b0;
    issue_valid = 1'b0;
    chk("ready_after_ack", 64'(issue_ready), 64'd1);
    chk("wb_dropped_after_ack", 64'(wb_valid), 64'd0);
  endtask

  // Reset lands mid-WAIT; the late unit result must not produce a writeback
  task automatic reset_mid_wait();
    int n;
    issue_op    = 1'b0;
    issue_a     = 32'd11;
    issue_b     = 16'd13;
    issue_rd    = 5'd4;
    issue_valid = 1'b1;
    n = 0;
    while (!issue_ready && n < 100) begin
      tick();
      n++;
    end
    start_q.push_back({1'b0, 32'd11, 16'd13});
    tick();
    issue_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check_reset_outputs("mid_wait_reset");
    reset_n      = 1'b1;
    md_resultRDY = 1'b1;
    md_result    = 32'hDEAD_BEEF;
    tick();
    md_resultRDY = 1'b0;
    repeat (4) begin
      chk("after_reset_no_wb", 64'(wb_valid), 64'd0);
      chk("after_reset_ready", 64'(issue_ready), 64'd1);
      tick();
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_op     = 1'b0;
    issue_a      = '0;
    issue_b      = '0;
    issue_rd     = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    wb_ack       = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    fork
      monitor();
    join_none

    run_op(1'b0, 32'd7, 16'd6, 5'd3, 15, 0, 1'b0, 1'b0);
    run_op(1'b1, 32'd100, 16'd0, 5'd5, 3, 1, 1'b0, 1'b0);
    run_op(1'b1, 32'd999, 16'd9, 5'd0, 4, 0, 1'b1, 1'b0);
    run_op(1'b1, 32'd1000, 16'd7, 5'd9, 2, 5, 1'b0, 1'b1);
    run_op(1'b0, 32'd3, 16'd5, 5'd7, 100, 2, 1'b0, 1'b0);
    run_op(1'b1, 32'd50, 16'd5, 5'd2, To - 1, 0, 1'b0, 1'b0);
    run_op(1'b0, 32'd1, 16'd1, 5'd1, 0, 0, 1'b1, 1'b0);
    reset_mid_wait();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        md_resultRDY = 1'b1;
        md_result    = $urandom;
        wb_ack       = 1'b1;
        tick();
        md_resultRDY = 1'b0;
        wb_ack       = 1'b0;
      end
      run_op(1'($urandom), $urandom,
             ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
             1'($urandom), 1'($urandom));
    end

    repeat (4) tick();
    chk("start_queue_drained", 64'(start_q.size()), 64'd0);
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
